result_bcd: RTL and testbench
=============================

# result_bcd

Downstream stage of the divider. It captures the divider's 8-bit quotient and 7-bit remainder whenever a new result is flagged. It then converts both to three-digit packed BCD in parallel, using a sequential shift-and-add-3 (double-dabble) engine. The BCD results go to the display/readout logic, with a one-cycle completion strobe.

## Interface
Parameters:
- None. All widths are fixed by the divider's result format.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- quotient  input  8  divider quotient, unsigned, 0..255.
- remainder  input  7  divider remainder, unsigned, 0..127.
- valid  input  1  divider result-valid flag; may be a pulse or a level.
- qbcd  output  12  quotient as BCD: [11:8] hundreds, [7:4] tens, [3:0] units.
- rbcd  output  12  remainder as BCD, same packing.
- done  output  1  single-cycle strobe; qbcd/rbcd updated this cycle.
- busy  output  1  high while a conversion is in progress.
- overrun  output  1  sticky; a new result arrived while busy and was dropped.

One clock; reset is asynchronous and active-low.

## Operation
- Start trigger: the rising edge of valid. Register valid_d each clock. Trigger = valid & ~valid_d.
  - A held-high valid gives exactly one trigger.
  - valid_d resets to 0, so a valid already high when reset releases triggers once.
- State machine: IDLE, CONV.
  - IDLE, trigger: load both shift registers, clear the 3-bit counter, go to CONV, busy = 1.
    - Quotient shift register: {12'b0, quotient} (20 bits).
    - Remainder shift register: {12'b0, 1'b0, remainder} (20 bits).
  - CONV, each clock, both registers in parallel:
    - Adjust: each BCD nibble (bits [19:16], [15:12], [11:8]) that is >= 5 gets +3.
    - Then shift the whole 20-bit register left by 1.
    - Increment the counter.
  - CONV with counter == 7 (the 8th shift):
    - Write the shifted bits [19:8] of each register into qbcd/rbcd.
    - Pulse done, clear busy, return to IDLE.
- Trigger while in CONV: the captured data is not disturbed and the in-flight conversion completes normally. Overrun is set and held until reset. The new result is dropped.
- qbcd/rbcd hold their last value between conversions. They change only on a done cycle.
- Every digit is 0..9. The hundreds digit is 0..2 for qbcd and 0..1 for rbcd. No illegal BCD values ever appear.

## Timing
- Reset values (reset = 0, immediate, asynchronous):
  - qbcd = 0, rbcd = 0, done = 0, busy = 0, overrun = 0.
  - State IDLE, counter 0, valid_d = 0, shift registers 0.
- Let edge E be the clock edge at which the trigger is sampled.
  - busy is high from after edge E until after edge E+8.
  - done is high for exactly the one cycle following edge E+8, when the new qbcd/rbcd are visible.
  - Latency is 8 clocks from capture to results.
- Back-to-back triggers: a trigger sampled at edge E+9 or later starts a new conversion. A trigger sampled at edges E+1..E+8 sets overrun.
- Trigger coinciding with the done edge (E+8): busy is still high when sampled, so it is dropped and sets overrun.
- Reset asserted mid-conversion: everything returns to reset values at once and no done is produced. After release, a valid still high produces a fresh trigger.
- quotient/remainder are sampled only at edge E. They may change afterwards without effect.

## Test plan
- Reset mid-conversion: assert reset at edge E+4 → busy = 0, done never pulses, qbcd = 0, rbcd = 0.
- Full scale: quotient = 255, remainder = 127, one-cycle valid pulse → done one cycle after edge E+8, qbcd = 12'h255, rbcd = 12'h127, busy high for exactly 8 cycles.
- Zero and digit boundaries, two separate triggers:
  - quotient = 0, remainder = 0 → qbcd = 12'h000, rbcd = 12'h000.
  - quotient = 100, remainder = 99 → qbcd = 12'h100, rbcd = 12'h099.
- Level valid: hold valid high for 30 cycles with quotient = 42, remainder = 5 → exactly one done pulse, qbcd = 12'h042, rbcd = 12'h005, overrun stays 0.
- Overrun:
  - Trigger with 200/3; deassert valid; re-pulse it at edge E+3 with 7/1 → done yields qbcd = 12'h200, rbcd = 12'h003, overrun = 1 until reset.
  - A later trigger with 7/1 after done yields qbcd = 12'h007, rbcd = 12'h001.
- Exhaustive sweep: all 256 quotients × 8 remainder samples, each triggered after the previous done → every qbcd/rbcd matches a decimal reference model. The bench checks every digit <= 9.

Source files
------------

// File: rtl/result_bcd.sv
// result_bcd: captures a divider result (8-bit quotient, 7-bit remainder) on
// the rising edge of valid and converts both values to three-digit packed BCD
// with a parallel pair of shift-and-add-3 (double-dabble) engines.
// A conversion takes 8 clocks. done pulses for one cycle when qbcd/rbcd update.
module result_bcd (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  quotient,
    input  logic [6:0]  remainder,
    input  logic        valid,
    output logic [11:0] qbcd,
    output logic [11:0] rbcd,
    output logic        done,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } state_t;

    state_t      state_r;
    logic        valid_d_r;
    logic [19:0] qsh_r;
    logic [19:0] rsh_r;
    logic [2:0]  cnt_r;

    logic        trig_s;
    logic [19:0] qnext_s;
    logic [19:0] rnext_s;

    // Add 3 to a BCD digit that is 5 or more, so that the following shift
    // carries correctly into the next decimal digit.
    function automatic logic [3:0] adj_nibble(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

    // One double-dabble iteration: adjust the three BCD digits, then shift
    // the whole register left by one bit.
    function automatic logic [19:0] dabble_step(input logic [19:0] v);
        logic [19:0] a;
        a        = v;
        a[19:16] = adj_nibble(v[19:16]);
        a[15:12] = adj_nibble(v[15:12]);
        a[11:8]  = adj_nibble(v[11:8]);
        return {a[18:0], 1'b0};
    endfunction

    assign trig_s  = valid & ~valid_d_r;
    assign qnext_s = dabble_step(qsh_r);
    assign rnext_s = dabble_step(rsh_r);

    // Capture/convert state machine with registered BCD outputs and flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            valid_d_r <= 1'b0;
            qsh_r     <= 20'd0;
            rsh_r     <= 20'd0;
            cnt_r     <= 3'd0;
            qbcd      <= 12'd0;
            rbcd      <= 12'd0;
            done      <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            valid_d_r <= valid;
            done      <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (trig_s) begin
                        qsh_r   <= {12'd0, quotient};
                        rsh_r   <= {12'd0, 1'b0, remainder};
                        cnt_r   <= 3'd0;
                        busy    <= 1'b1;
                        state_r <= ST_CONV;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CONV: begin
                    // A new result while converting is dropped and flagged.
                    if (trig_s) begin
                        overrun <= 1'b1;
                    end else begin
                        overrun <= overrun;
                    end
                    qsh_r <= qnext_s;
                    rsh_r <= rnext_s;
                    cnt_r <= cnt_r + 3'd1;
                    if (cnt_r == 3'd7) begin
                        qbcd    <= qnext_s[19:8];
                        rbcd    <= rnext_s[19:8];
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_CONV;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_bcd.sv
// tb_result_bcd: scoreboard bench for result_bcd. Stimulus pushes the decimal
// reference result into a queue; a monitor pops and compares on every done.
module tb_result_bcd;

    logic        clk;
    logic        reset;
    logic [7:0]  quotient;
    logic [6:0]  remainder;
    logic        valid;
    logic [11:0] qbcd;
    logic [11:0] rbcd;
    logic        done;
    logic        busy;
    logic        overrun;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [23:0] exp_q[$];

    result_bcd dut (
        .clk       (clk),
        .reset     (reset),
        .quotient  (quotient),
        .remainder (remainder),
        .valid     (valid),
        .qbcd      (qbcd),
        .rbcd      (rbcd),
        .done      (done),
        .busy      (busy),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal reference: hundreds/tens/units by plain division.
    function automatic logic [11:0] dec3(input int v);
        logic [3:0] h, t, u;
        h = 4'((v / 100) % 10);
        t = 4'((v / 10) % 10);
        u = 4'(v % 10);
        return {h, t, u};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each done and checks digits and busy span.
    initial begin
        int busy_run = 0;
        logic prev_done = 1'b0;
        logic [23:0] e;
        forever begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                chk("done_single", int'(prev_done), 0);
                chk("busy_span", busy_run, 8);
                chk("busy_low_at_done", int'(busy), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("qbcd", int'(qbcd), int'(e[23:12]));
                    chk("rbcd", int'(rbcd), int'(e[11:0]));
                end
                for (int d = 0; d < 3; d++) begin
                    chk("qdigit_le9", int'(qbcd[d*4 +: 4] <= 4'd9), 1);
                    chk("rdigit_le9", int'(rbcd[d*4 +: 4] <= 4'd9), 1);
                end
            end
            if (busy) busy_run++;
            else busy_run = 0;
            prev_done = done;
        end
    end

    // One-cycle valid pulse; inputs scrambled afterwards (must not matter).
    task automatic pulse(input int q, input int r, input bit expect_it);
        @(negedge clk);
        quotient  = 8'(q);
        remainder = 7'(r);
        valid     = 1'b1;
        if (expect_it) exp_q.push_back({dec3(q), dec3(r)});
        @(negedge clk);
        valid     = 1'b0;
        quotient  = 8'($urandom);
        remainder = 7'($urandom);
    endtask

    task automatic wait_done();
        int start;
        bit seen;
        start = done_cnt;
        seen  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt != start) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int base;
        reset     = 1'b0;
        valid     = 1'b0;
        quotient  = 8'd0;
        remainder = 7'd0;
        repeat (3) @(negedge clk);
        chk("rst_qbcd", int'(qbcd), 0);
        chk("rst_rbcd", int'(rbcd), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overrun", int'(overrun), 0);
        reset = 1'b1;

        // Full scale.
        pulse(255, 127, 1'b1);
        wait_done();

        // Reset mid-conversion: outputs clear at once, no done afterwards.
        pulse(123, 45, 1'b0);
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_qbcd", int'(qbcd), 0);
        chk("midrst_rbcd", int'(rbcd), 0);
        base = done_cnt;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        chk("midrst_no_done", done_cnt, base);

        // Zero and digit boundaries.
        pulse(0, 0, 1'b1);
        wait_done();
        pulse(100, 99, 1'b1);
        wait_done();

        // Level valid: one conversion only.
        base = done_cnt;
        @(negedge clk);
        quotient  = 8'd42;
        remainder = 7'd5;
        valid     = 1'b1;
        exp_q.push_back({dec3(42), dec3(5)});
        repeat (30) @(negedge clk);
        valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("level_one_done", done_cnt, base + 1);
        chk("level_overrun", int'(overrun), 0);

        // Overrun: second pulse sampled at E+3 is dropped.
        pulse(200, 3, 1'b1);
        @(negedge clk);
        pulse(7, 1, 1'b0);
        wait_done();
        chk("overrun_set", int'(overrun), 1);
        pulse(7, 1, 1'b1);
        wait_done();
        chk("overrun_sticky", int'(overrun), 1);
        do_reset();
        chk("overrun_cleared", int'(overrun), 0);

        // Valid held across reset release triggers a fresh conversion.
        @(negedge clk);
        reset     = 1'b0;
        quotient  = 8'd88;
        remainder = 7'd64;
        valid     = 1'b1;
        exp_q.push_back({dec3(88), dec3(64)});
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        wait_done();

        // Sweep: every quotient with 8 remainder samples incl. 0 and 127.
        for (int q = 0; q < 256; q++) begin
            for (int k = 0; k < 8; k++) begin
                int r;
                if (k == 0) r = 0;
                else if (k == 1) r = 127;
                else r = int'($urandom_range(0, 127));
                pulse(q, r, 1'b1);
                wait_done();
            end
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
